// File: rtl/inst_encoder_loader.sv
// ---------------------------------------------------------------------------
// inst_encoder_loader
//
// Purpose:
//   Encoder and program loader for the scalar/vector instruction format.
//   - Accepts field-level instruction requests (opcode, register fields and
//     an immediate).
//   - Packs each request into a 32-bit instruction word.
//   - Streams the words into instruction memory at sequential word addresses.
//   - Requests whose immediate does not fit the selected format are
//     rejected and counted. So are requests that arrive after memory is full.
//
// Parameters:
//   ADDR_W  instruction memory word-address width
//   DEPTH   number of writable words (last address DEPTH-1, DEPTH <= 2**ADDR_W)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      pulse in IDLE: clear address/counters/errors, begin session
//   in_valid   request valid
//   in_ready   request accepted when in_valid & in_ready
//   in_opcode  7-bit opcode, copied to word[31:25]
//   in_rd      rd/vd field
//   in_rn      rn/vn field
//   in_rm      rm/vm field
//   in_imm     25-bit zero-extended immediate
//   in_last    marks the final request of the session
//   mem_we     write strobe, held until mem_ready
//   mem_ready  memory accepts the write when mem_we & mem_ready
//   mem_addr   word address of the current / next write
//   mem_wdata  encoded instruction word
//   busy       session active (state is not IDLE)
//   done       one-cycle pulse at the end of a session
//   err        sticky error flag since the last start
//   err_cnt    number of rejected requests, saturating at 255
//   word_cnt   number of words written this session
// ---------------------------------------------------------------------------
module inst_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [24:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

  // Operand layouts of the instruction format. The opcode always sits in
  // word[31:25]. Every bit a layout does not use is zero.
  typedef enum logic [1:0] {
    FMT_IMM15,      // imm[14:0]@[14:0]
    FMT_REG3,       // rd@[24:20], rn@[19:15], rm@[14:10]
    FMT_REG2_IMM15, // rd@[24:20], rn@[19:15], imm[14:0]@[14:0]
    FMT_IMM25       // imm[24:0]@[24:0]
  } fmt_t;

  state_t state, state_next;
  fmt_t   fmt;

  logic [1:0]  op_class;
  logic        op_form;
  logic [31:0] enc_word;
  logic        imm_ok;
  logic        full;
  logic        accept;
  logic        accept_ok;
  logic        accept_rej;
  logic        write_done;
  logic        last_q;

  // The class is opcode[6:5] and the form bit is opcode[3]. The vector flag
  // (opcode[4]) only travels along inside the opcode field. It does not
  // change the layout.
  assign op_class = in_opcode[6:5];
  assign op_form  = in_opcode[3];

  always_comb begin
    fmt = FMT_REG3;
    case (op_class)
      2'b00:   fmt = op_form ? FMT_REG3       : FMT_IMM15;
      2'b01:   fmt = op_form ? FMT_REG2_IMM15 : FMT_REG3;
      2'b10:   fmt = FMT_REG2_IMM15;
      2'b11:   fmt = op_form ? FMT_IMM25      : FMT_REG2_IMM15;
      default: fmt = FMT_REG3;
    endcase
  end

  always_comb begin
    enc_word = {in_opcode, 25'd0};
    case (fmt)
      FMT_IMM15: begin
        enc_word[14:0] = in_imm[14:0];
      end
      FMT_REG3: begin
        enc_word[24:20] = in_rd;
        enc_word[19:15] = in_rn;
        enc_word[14:10] = in_rm;
      end
      FMT_REG2_IMM15: begin
        enc_word[24:20] = in_rd;
        enc_word[19:15] = in_rn;
        enc_word[14:0]  = in_imm[14:0];
      end
      FMT_IMM25: begin
        enc_word[24:0] = in_imm;
      end
      default: begin
        enc_word = {in_opcode, 25'd0};
      end
    endcase
  end

  // A 15-bit immediate field cannot hold any set bit above bit 14. The full
  // 25-bit layout uses every bit, and register-only layouts ignore the
  // immediate, so both of those always pass the range check.
  always_comb begin
    imm_ok = 1'b1;
    if ((fmt == FMT_IMM15) || (fmt == FMT_REG2_IMM15)) begin
      imm_ok = (in_imm[24:15] == 10'd0);
    end
  end

  assign full       = (word_cnt == DEPTH_CNT);
  assign accept     = (state == LOAD) && in_valid;
  assign accept_ok  = accept && imm_ok && !full;
  assign accept_rej = accept && !(imm_ok && !full);
  assign write_done = (state == WRITE) && mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake strobes are decoded from the state. mem_we therefore falls
  // together with the asynchronous reset of the state register.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (accept_ok) begin
          state_next = WRITE;
        end else if (accept_rej && in_last) begin
          state_next = DONE;
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        if (mem_ready) begin
          state_next = last_q ? DONE : LOAD;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Session datapath: address, counters, error flags and the word held for
  // the memory write.
  // - start only reaches this logic in IDLE. It is ignored while busy and
  //   in the DONE cycle.
  // - After the last address the address counter holds instead of
  //   incrementing, so it never wraps. The full condition then rejects
  //   any further requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      word_cnt  <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
      last_q    <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        mem_addr <= '0;
        word_cnt <= '0;
        err      <= 1'b0;
        err_cnt  <= '0;
      end
      if (accept_ok) begin
        mem_wdata <= enc_word;
        last_q    <= in_last;
      end
      if (accept_rej) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
      if (write_done) begin
        word_cnt <= word_cnt + (ADDR_W + 1)'(1);
        if (mem_addr != LAST_ADDR) begin
          mem_addr <= mem_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_encoder_loader
//
// Directed bench for inst_encoder_loader. It instantiates a DEPTH=4,
// ADDR_W=2 loader so that the full condition and the last-address hold are
// reachable within a few requests.
// ---------------------------------------------------------------------------
module tb_inst_encoder_loader;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rn;
  logic [4:0]        in_rm;
  logic [24:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        err_cnt;
  logic [ADDR_W:0]   word_cnt;

  int checks = 0;
  int errors = 0;

  inst_encoder_loader #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_opcode(in_opcode),
    .in_rd    (in_rd),
    .in_rn    (in_rn),
    .in_rm    (in_rm),
    .in_imm   (in_imm),
    .in_last  (in_last),
    .mem_we   (mem_we),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_cnt  (err_cnt),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one request, wait (bounded) for in_ready, then hold it for the
  // accepting edge.
  task automatic apply_stimulus(input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rn, input logic [4:0] rm,
                                input logic [24:0] imm, input logic last);
    int n;
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_rn     = rn;
    in_rm     = rm;
    in_imm    = imm;
    in_last   = last;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) begin
      check_output("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic complete_write();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_rd     = '0;
    in_rn     = '0;
    in_rm     = '0;
    in_imm    = '0;
    in_last   = 1'b0;
    mem_ready = 1'b0;
    step();
    step();

    // Reset state
    check_output("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_done", {31'd0, done}, 32'd0);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("rst_err", {31'd0, err}, 32'd0);
    check_output("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check_output("rst_word_cnt", {29'd0, word_cnt}, 32'd0);
    check_output("rst_mem_addr", {30'd0, mem_addr}, 32'd0);
    check_output("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    step();

    // Single register-form word with a stalled memory
    pulse_start();
    check_output("s1_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("s1_busy", {31'd0, busy}, 32'd1);
    apply_stimulus(7'b0100000, 5'd3, 5'd4, 5'd5, 25'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_output("s1_stall_we", {31'd0, mem_we}, 32'd1);
      check_output("s1_stall_addr", {30'd0, mem_addr}, 32'd0);
      check_output("s1_stall_wdata", mem_wdata, 32'h40321400);
      check_output("s1_stall_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    complete_write();
    check_output("s1_done", {31'd0, done}, 32'd1);
    check_output("s1_done_we", {31'd0, mem_we}, 32'd0);
    check_output("s1_word_cnt", {29'd0, word_cnt}, 32'd1);
    step();
    check_output("s1_idle_done", {31'd0, done}, 32'd0);
    check_output("s1_idle_busy", {31'd0, busy}, 32'd0);

    // Three-word sequence covering the imm15, imm25 and reg2+imm15 layouts
    pulse_start();
    apply_stimulus(7'b0000000, 5'd0, 5'd0, 5'd0, 25'h0001234, 1'b0);
    check_output("s2_w0_data", mem_wdata, 32'h00001234);
    check_output("s2_w0_addr", {30'd0, mem_addr}, 32'd0);
    complete_write();
    apply_stimulus(7'b1101000, 5'd0, 5'd0, 5'd0, 25'h1ABCDEF, 1'b0);
    check_output("s2_w1_data", mem_wdata, 32'hD1ABCDEF);
    check_output("s2_w1_addr", {30'd0, mem_addr}, 32'd1);
    complete_write();
    apply_stimulus(7'b0101000, 5'd1, 5'd2, 5'd0, 25'h0007FFF, 1'b1);
    check_output("s2_w2_data", mem_wdata, 32'h50117FFF);
    check_output("s2_w2_addr", {30'd0, mem_addr}, 32'd2);
    complete_write();
    check_output("s2_done", {31'd0, done}, 32'd1);
    check_output("s2_word_cnt", {29'd0, word_cnt}, 32'd3);
    step();

    // Out-of-range immediate, start while busy, then fill to DEPTH
    pulse_start();
    apply_stimulus(7'b1000000, 5'd0, 5'd0, 5'd0, 25'h0008000, 1'b0);
    check_output("s3_rej_we", {31'd0, mem_we}, 32'd0);
    check_output("s3_rej_err", {31'd0, err}, 32'd1);
    check_output("s3_rej_err_cnt", {24'd0, err_cnt}, 32'd1);
    check_output("s3_rej_addr", {30'd0, mem_addr}, 32'd0);
    check_output("s3_rej_in_ready", {31'd0, in_ready}, 32'd1);
    pulse_start();
    check_output("s3_busy_start_err_cnt", {24'd0, err_cnt}, 32'd1);
    check_output("s3_busy_start_err", {31'd0, err}, 32'd1);
    check_output("s3_busy_start_ready", {31'd0, in_ready}, 32'd1);
    // Register-only layout must ignore a wide immediate
    apply_stimulus(7'b0100000, 5'd3, 5'd4, 5'd5, 25'h1FFFFFF, 1'b0);
    check_output("s3_w0_we", {31'd0, mem_we}, 32'd1);
    check_output("s3_w0_addr", {30'd0, mem_addr}, 32'd0);
    check_output("s3_w0_data", mem_wdata, 32'h40321400);
    complete_write();
    apply_stimulus(7'b0001000, 5'd31, 5'd0, 5'd1, 25'd0, 1'b0);
    check_output("s3_w1_addr", {30'd0, mem_addr}, 32'd1);
    check_output("s3_w1_data", mem_wdata, 32'h11F00400);
    complete_write();
    apply_stimulus(7'b1110000, 5'd2, 5'd3, 5'd0, 25'h0007FFF, 1'b0);
    check_output("s3_w2_addr", {30'd0, mem_addr}, 32'd2);
    check_output("s3_w2_data", mem_wdata, 32'hE021FFFF);
    complete_write();
    apply_stimulus(7'b0010000, 5'd0, 5'd0, 5'd0, 25'h0000005, 1'b0);
    check_output("s3_w3_addr", {30'd0, mem_addr}, 32'd3);
    check_output("s3_w3_data", mem_wdata, 32'h20000005);
    complete_write();
    check_output("s3_full_word_cnt", {29'd0, word_cnt}, 32'd4);
    check_output("s3_full_addr", {30'd0, mem_addr}, 32'd3);
    apply_stimulus(7'b0100000, 5'd1, 5'd1, 5'd1, 25'd0, 1'b1);
    check_output("s3_over_we", {31'd0, mem_we}, 32'd0);
    check_output("s3_over_err_cnt", {24'd0, err_cnt}, 32'd2);
    check_output("s3_over_addr", {30'd0, mem_addr}, 32'd3);
    check_output("s3_over_done", {31'd0, done}, 32'd1);
    // start in the DONE cycle is ignored
    pulse_start();
    check_output("s3_done_start_busy", {31'd0, busy}, 32'd0);
    check_output("s3_done_start_err_cnt", {24'd0, err_cnt}, 32'd2);
    pulse_start();
    check_output("s3_restart_err", {31'd0, err}, 32'd0);
    check_output("s3_restart_err_cnt", {24'd0, err_cnt}, 32'd0);
    check_output("s3_restart_word_cnt", {29'd0, word_cnt}, 32'd0);
    check_output("s3_restart_addr", {30'd0, mem_addr}, 32'd0);
    check_output("s3_restart_busy", {31'd0, busy}, 32'd1);

    // Asynchronous reset in the middle of a stalled write
    apply_stimulus(7'b0000000, 5'd0, 5'd0, 5'd0, 25'h1000000, 1'b0);
    check_output("s4_rej_err", {31'd0, err}, 32'd1);
    apply_stimulus(7'b0000000, 5'd0, 5'd0, 5'd0, 25'h0000001, 1'b0);
    complete_write();
    apply_stimulus(7'b0000000, 5'd0, 5'd0, 5'd0, 25'h0000002, 1'b0);
    check_output("s4_pre_we", {31'd0, mem_we}, 32'd1);
    check_output("s4_pre_addr", {30'd0, mem_addr}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("s4_async_we", {31'd0, mem_we}, 32'd0);
    check_output("s4_async_busy", {31'd0, busy}, 32'd0);
    check_output("s4_async_err", {31'd0, err}, 32'd0);
    #3;
    rst_n = 1'b1;
    step();
    pulse_start();
    apply_stimulus(7'b0100000, 5'd3, 5'd4, 5'd5, 25'd0, 1'b1);
    check_output("s4_restart_addr", {30'd0, mem_addr}, 32'd0);
    check_output("s4_restart_data", mem_wdata, 32'h40321400);
    check_output("s4_restart_we", {31'd0, mem_we}, 32'd1);
    complete_write();
    check_output("s4_done", {31'd0, done}, 32'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Encoder side of the scalar/vector instruction format: turns field-level instruction requests into packed 32-bit instruction words.
- Streams the words into instruction memory at sequential addresses, giving the program-load path for the fetch/decode front end.
- Checks immediate ranges per format and reports errors.
- Per-word handshake on both input and memory sides.

Parameters:
- ADDR_W, 8, instruction memory address width (word addresses)
- DEPTH, 256, words available; last writable address DEPTH-1 (DEPTH <= 2**ADDR_W)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: clear address/counters/errors and begin a load session
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_opcode  in  7  becomes word[31:25]
- in_rd  in  5  rd/vd field
- in_rn  in  5  rn/vn field
- in_rm  in  5  rm/vm field
- in_imm  in  25  immediate, zero-extended input
- in_last  in  1  marks final request of session
- mem_we  out  1  write strobe, held until mem_ready
- mem_ready  in  1  memory accepts write when mem_we & mem_ready
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded word
- busy  out  1  session active (not IDLE)
- done  out  1  one-cycle pulse at end of session
- err  out  1  sticky error since last start
- err_cnt  out  8  rejected requests, saturates at 255
- word_cnt  out  ADDR_W+1  words written this session

Behaviour:
- Reset: state IDLE; all outputs 0; address counter 0.
- Encoding uses class = opcode[6:5], vector flag = opcode[4] (pass-through only), form bit = opcode[3]. All unused bits are 0.
  - class 00, form 0: word[14:0]=imm[14:0]
  - class 00, form 1: rd@[24:20], rn@[19:15], rm@[14:10]
  - class 01, form 0: rd, rn, rm
  - class 01, form 1: rd, rn, imm[14:0]@[14:0]
  - class 10: rd, rn, imm[14:0] (form bit ignored for layout)
  - class 11, form 0: rd, rn, imm[14:0]
  - class 11, form 1: imm[24:0]@[24:0]
- Range check: imm15 formats require in_imm[24:10+5]==0 (in_imm[24:15]==0), else the request is rejected. Register-only formats ignore in_imm.
- FSM IDLE -> LOAD -> WRITE -> (LOAD | DONE) -> IDLE:
  - IDLE: in_ready=0. start -> LOAD; clear mem_addr, word_cnt, err, err_cnt.
  - LOAD: in_ready=1. On accept of a valid-range request: register word and address, go to WRITE; mem_we=1 in the next cycle (latency 1).
  - On accept of a rejected request: no write; err=1; err_cnt++; address unchanged. If in_last -> DONE, else stay in LOAD.
  - WRITE: in_ready=0; mem_we/mem_addr/mem_wdata stable until mem_ready. On completion: word_cnt++, address++. Then in_last -> DONE, else -> LOAD.
  - DONE: done=1 for one cycle, busy=0 next cycle -> IDLE.
- Full: once word_cnt==DEPTH, any further accepted request is rejected (err, err_cnt++) with no write and no address wrap.
- start while busy: ignored. start is ignored in the same cycle as DONE.
- Async reset mid-write: mem_we drops immediately; session is abandoned.
- err_cnt saturates at 255.

Test Plan:
- start; opcode=7'b0100000, rd=3, rn=4, rm=5 -> mem_we next cycle, mem_addr=0, mem_wdata=0x40321400; mem_ready held 0 for 3 cycles keeps all mem outputs stable.
- Sequence: opcode 7'b0000000 imm=0x1234 -> 0x00001234 @0; opcode 7'b1101000 imm=0x1ABCDEF -> 0xD1ABCDEF @1; opcode 7'b0101000 rd=1 rn=2 imm=0x7FFF with in_last -> 0x50117FFF @2; then done pulse; word_cnt=3.
- Overflow: opcode 7'b1000000 imm=0x8000 -> no mem_we, err=1, err_cnt=1, next valid word still written at the unadvanced address.
- DEPTH=4: five requests -> addresses 0..3 written, fifth rejected, err_cnt=1, mem_addr never wraps.
- Assert rst_n low during WRITE with mem_ready=0 -> mem_we, busy, err clear asynchronously; new start restarts at address 0.
- start pulsed while busy -> no effect on address or counters; start after done clears err and err_cnt.
